parallel_recv_chk: RTL
======================

// Module: parallel_recv_chk
// PURPOSE
//  Parametrised successor to the parallel-link receive checker. Sits after the
//  word aligner and checks a test burst of BURST_LEN words against a generated
//  reference; counts mismatching words in a saturating counter.
//  Self-seeding: the first word of each burst sets the reference, so the TX
//  start value is free. Adds a burst-done strobe, a busy flag and a pipelined
//  compare. PRBS pattern mode is optional.
// PARAMETERS
//  DW        32    data word width (>=8)
//  BURST_LEN 1024  words per burst including seed word (>=2)
//  ECW       8     ERR_CNT width
//  LFSR_TAP  28    feedback tap bit index for PRBS mode (1..DW-1)
// PORTS
//  CLK        in   1    clock, single domain
//  RST        in   1    synchronous reset, active-high
//  CLR        in   1    sync clear of all state incl. ERR_CNT
//  ALIGNED    in   1    aligner locked; gates DIPUSH
//  DIPUSH     in   1    DIN valid this cycle
//  DIN        in   DW   received word
//  INIT       in   1    start/restart burst (level sampled, registered)
//  MODE       in   1    0 = increment, 1 = PRBS (only with PRBS_MODE_EN)
//  ERR_CNT    out  ECW  mismatching words, saturating
//  BUSY       out  1    burst in progress (SEED or RUN)
//  BURST_DONE out  1    1-cycle pulse when last word's result is in ERR_CNT
// BEHAVIOUR
//  - Reset values (RST or CLR): ERR_CNT=0, BUSY=0, BURST_DONE=0, state IDLE,
//    ref=0, remaining=0, pipeline valids=0. Priority RST > CLR > init_d1 > word.
//  - word = ALIGNED & DIPUSH. init_d1 = INIT delayed 1 cycle.
//  - FSM: IDLE --init_d1--> SEED --word--> RUN --last word--> IDLE.
//    init_d1 in any state -> SEED (restart mid-burst); a word in the init_d1
//    cycle is discarded.
//  - SEED: word loads ref <= next(DIN), remaining <= BURST_LEN-1; not checked.
//  - RUN: per word: stage1 regs {v1,din1,ref1} <= {1,DIN,ref}; ref <= next(ref);
//    remaining--; if remaining==1 -> IDLE and tag stage1 as last.
//  - Stage2 (next cycle): if v1 && din1!=ref1, ERR_CNT++ unless all-ones
//    (sticks at 2^ECW-1). ERR_CNT updated 2 cycles after word sampled.
//    BURST_DONE=1 in that same cycle for the tagged last word.
//  - Words in IDLE, or with ALIGNED=0, ignored: no ref/remaining change.
//  - Restart while words in stage1: those still compared; last tag cleared, no
//    BURST_DONE for the aborted burst. ERR_CNT not cleared by INIT (only CLR/RST).
//  - Reference does not resync on error: one corrupt word = one error.
//  - next(x): increment: x + 1 mod 2^DW.
//    PRBS: {x[DW-2:0], x[DW-1]^x[LFSR_TAP-1]}. An all-zero seed in PRBS stays
//    zero and is legal (checked as constant).
//  - remaining width = $clog2(BURST_LEN)+1. No combinational in->out paths.
// CONFIGURATION
//  - PRBS_MODE_EN defined: MODE selects next() per burst, sampled at the seed
//    word and held for the burst; MODE changes mid-burst ignored.
//  - PRBS_MODE_EN undefined: MODE unused, increment only; no LFSR logic.
// TESTING
//  1 RST=1 two cycles, DIPUSH toggling -> ERR_CNT=0, BUSY=0, BURST_DONE=0.
//  2 INIT, 1024 words 0x100..0x4FF back-to-back -> ERR_CNT=0, BUSY falls after
//    last word, BURST_DONE one pulse 2 cycles after last word.
//  3 Same, word #5 = 0x105^0x1 -> ERR_CNT=1; words #6.. still match.
//  4 ECW=8, 300 corrupted words -> ERR_CNT=255 held; CLR -> 0 next cycle.
//  5 Bubbles: DIPUSH low gaps and 10 words with ALIGNED=0 in burst -> ignored;
//    ERR_CNT=0, burst ends after 1024 accepted words.
//  6 PRBS_MODE_EN, MODE=1, seed 0x1, clean LFSR stream -> ERR_CNT=0; INIT at
//    word 500 -> no BURST_DONE for burst 1, new burst seeds, completes normally.

Source files
------------

// File: rtl/parallel_recv_chk_if.sv
// Receive-side bus for parallel_recv_chk: aligned word stream in, error/burst status out.
interface parallel_recv_chk_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned ECW = 8
);
    logic          ALIGNED;
    logic          DIPUSH;
    logic [DW-1:0] DIN;
    logic          INIT;
    logic          MODE;
    logic [ECW-1:0] ERR_CNT;
    logic          BUSY;
    logic          BURST_DONE;

    modport master (
        output ALIGNED, DIPUSH, DIN, INIT, MODE,
        input  ERR_CNT, BUSY, BURST_DONE
    );

    modport slave (
        input  ALIGNED, DIPUSH, DIN, INIT, MODE,
        output ERR_CNT, BUSY, BURST_DONE
    );
endinterface

// File: rtl/parallel_recv_chk.sv
// Self-seeding burst checker: compares BURST_LEN received words against a generated reference.
// Define PRBS_MODE_EN to add the LFSR pattern selectable per burst via MODE.
module parallel_recv_chk #(
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_LEN = 1024,
    parameter int unsigned ECW       = 8,
    parameter int unsigned LFSR_TAP  = 28
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    parallel_recv_chk_if.slave  bus
);
    localparam int unsigned RW = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

    state_t         state_q, state_n;
    logic           init_d1;
    logic [DW-1:0]  ref_q, ref_n;
    logic [RW-1:0]  rem_q, rem_n;
    logic           v1_q, v1_n;
    logic           last1_q, last1_n;
    logic [DW-1:0]  din1_q, ref1_q;
    logic [ECW-1:0] err_q;
    logic           done_q;
    logic           word;
    logic [DW-1:0]  seed_next, run_next;

    assign word = bus.ALIGNED & bus.DIPUSH;

`ifdef PRBS_MODE_EN
    logic mode_q;

    function automatic logic [DW-1:0] next_ref(input logic [DW-1:0] x, input logic prbs);
        if (prbs)
            return {x[DW-2:0], x[DW-1] ^ x[LFSR_TAP-1]};
        return x + DW'(1);
    endfunction

    // Pattern is latched with the seed word so MODE may change freely mid-burst.
    assign seed_next = next_ref(bus.DIN, bus.MODE);
    assign run_next  = next_ref(ref_q, mode_q);

    always_ff @(posedge CLK) begin
        if (RST || CLR)
            mode_q <= 1'b0;
        else if (!init_d1 && word && state_q == SEED)
            mode_q <= bus.MODE;
    end
`else
    logic unused_mode;
    assign unused_mode = bus.MODE;
    assign seed_next   = bus.DIN + DW'(1);
    assign run_next    = ref_q + DW'(1);
`endif

    always_comb begin
        state_n = state_q;
        ref_n   = ref_q;
        rem_n   = rem_q;
        v1_n    = 1'b0;
        last1_n = 1'b0;
        if (init_d1) begin
            state_n = SEED;
        end else if (word) begin
            case (state_q)
                SEED: begin
                    ref_n   = seed_next;
                    rem_n   = RW'(BURST_LEN - 1);
                    state_n = RUN;
                end
                RUN: begin
                    v1_n  = 1'b1;
                    ref_n = run_next;
                    rem_n = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        state_n = IDLE;
                        last1_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state_q <= IDLE;
            init_d1 <= 1'b0;
            ref_q   <= '0;
            rem_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            din1_q  <= '0;
            ref1_q  <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            init_d1 <= bus.INIT;
            ref_q   <= ref_n;
            rem_q   <= rem_n;
            v1_q    <= v1_n;
            last1_q <= last1_n;
            if (v1_n) begin
                din1_q <= bus.DIN;
                ref1_q <= ref_q;
            end
            // Words already in stage1 at a restart are still scored, but the aborted burst never reports done.
            if (v1_q && din1_q != ref1_q && err_q != '1)
                err_q <= err_q + ECW'(1);
            done_q <= v1_q & last1_q & ~init_d1;
        end
    end

    assign bus.ERR_CNT    = err_q;
    assign bus.BUSY       = (state_q != IDLE);
    assign bus.BURST_DONE = done_q;
endmodule
